// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory line arbiter.
//   arb_state_e : FSM encoding, also exported on dbg_state
//   PRIO_*      : values for the arbiter PRIO_MODE parameter
//   *_DEF       : default line-port widths used by the bus interface
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWait    = 2'd2,
    StRelease = 2'd3
  } arb_state_e;

  localparam int unsigned PRIO_RR    = 0;  // round-robin between m0 and m1
  localparam int unsigned PRIO_FIXED = 1;  // m1 always wins

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 512;
  localparam int unsigned DM_W_DEF   = DATA_W_DEF / 8;

endpackage

// File: rtl/mem_line_arbiter_if.sv
// Line-port bundle between the two cache masters, the arbiter and the wrapper.
//   m_stb/m_we, m{0,1}_addr/din/dm : master requests (held until m_ack)
//   m_ack, m_dout                  : completion pulse and broadcast read data
//   ws_*                           : single-transaction port into the wrapper
// Modports:
//   slave  : the arbiter's view (takes master requests, drives the wrapper)
//   master : the environment's view (drives requests and wrapper responses)
interface mem_line_arbiter_if #(
  parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = mem_arb_pkg::DATA_W_DEF,
  parameter int unsigned DM_W   = mem_arb_pkg::DM_W_DEF
);

  logic [1:0]        m_stb;
  logic [1:0]        m_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m0_din;
  logic [DATA_W-1:0] m1_din;
  logic [DM_W-1:0]   m0_dm;
  logic [DM_W-1:0]   m1_dm;
  logic [1:0]        m_ack;
  logic [DATA_W-1:0] m_dout;

  logic [ADDR_W-1:0] ws_addr;
  logic [DATA_W-1:0] ws_din;
  logic [DM_W-1:0]   ws_dm;
  logic              ws_cyc;
  logic              ws_stb;
  logic              ws_we;
  logic              ws_ack;
  logic [DATA_W-1:0] ws_dout;

  modport slave (
    input  m_stb, m_we, m0_addr, m1_addr, m0_din, m1_din, m0_dm, m1_dm,
    input  ws_ack, ws_dout,
    output m_ack, m_dout,
    output ws_addr, ws_din, ws_dm, ws_cyc, ws_stb, ws_we
  );

  modport master (
    output m_stb, m_we, m0_addr, m1_addr, m0_din, m1_din, m0_dm, m1_dm,
    output ws_ack, ws_dout,
    input  m_ack, m_dout,
    input  ws_addr, ws_din, ws_dm, ws_cyc, ws_stb, ws_we
  );

endinterface

// File: rtl/arb_pick2.sv
// Two-way grant selection, purely combinational.
//   req_i        : per-master request
//   last_grant_i : master served most recently
//   prio_mode_i  : 1 = fixed priority (m1 wins), 0 = round-robin
//   grant_o      : index of the winning master (meaningful only when |req_i)
module arb_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       prio_mode_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = 1'b0;
    if (prio_mode_i) begin
      grant_o = req_i[1];
    end else if (&req_i) begin
      // Tie: the master not served last time goes first.
      grant_o = ~last_grant_i;
    end else begin
      grant_o = req_i[1];
    end
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares the wrapper's 512-bit line port between the I-cache (m0) and the
// D-cache (m1). One wrapper transaction at a time: IDLE picks a winner and
// latches its request, ISSUE strobes for one cycle, WAIT holds the request
// until ws_ack, RELEASE is a dead cycle so a just-served master's still-high
// m_stb is not mistaken for a new request.
// Ports:
//   clkCPU    : clock, all logic on posedge
//   rst       : synchronous active-high reset
//   bus       : line-port bundle (widths come from the interface parameters)
//   busy      : FSM not in IDLE
//   dbg_state : current FSM state encoding
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned PRIO_MODE = PRIO_RR
) (
  input  logic              clkCPU,
  input  logic              rst,
  mem_line_arbiter_if.slave bus,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  arb_state_e state_q;
  logic       grant_q;
  logic       last_grant_q;
  logic       pick;

  arb_pick2 u_pick (
    .req_i        (bus.m_stb),
    .last_grant_i (last_grant_q),
    .prio_mode_i  (PRIO_MODE == PRIO_FIXED),
    .grant_o      (pick)
  );

  always_ff @(posedge clkCPU) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;  // so m0 wins the first tie
      bus.ws_addr  <= '0;
      bus.ws_din   <= '0;
      bus.ws_dm    <= '0;
      bus.ws_we    <= 1'b0;
      bus.ws_stb   <= 1'b0;
      bus.ws_cyc   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|bus.m_stb) begin
            grant_q     <= pick;
            bus.ws_addr <= pick ? bus.m1_addr : bus.m0_addr;
            bus.ws_din  <= pick ? bus.m1_din  : bus.m0_din;
            bus.ws_dm   <= pick ? bus.m1_dm   : bus.m0_dm;
            bus.ws_we   <= bus.m_we[pick];
            bus.ws_stb  <= 1'b1;
            bus.ws_cyc  <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          bus.ws_stb <= 1'b0;
          state_q    <= StWait;
        end
        StWait: begin
          if (bus.ws_ack) begin
            last_grant_q <= grant_q;
            bus.ws_cyc   <= 1'b0;
            state_q      <= StRelease;
          end
        end
        StRelease: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ack is passed through in the same cycle; a stray ws_ack outside WAIT is dropped.
  always_comb begin
    bus.m_ack = 2'b00;
    if (state_q == StWait && bus.ws_ack) begin
      bus.m_ack[grant_q] = 1'b1;
    end
  end

  assign bus.m_dout = bus.ws_dout;
  assign busy       = (state_q != StIdle);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
module tb_mem_line_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 512;
  localparam int unsigned MW = 64;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] din;
    logic [MW-1:0] dm;
  } req_t;

  logic clkCPU = 1'b0;
  logic rst    = 1'b1;
  always #5 clkCPU = ~clkCPU;

  // ---------------- round-robin instance ----------------
  mem_line_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .DM_W(MW)) bus_r ();
  logic       busy_r;
  logic [1:0] st_r;

  mem_line_arbiter #(.PRIO_MODE(PRIO_RR)) u_dut_rr (
    .clkCPU    (clkCPU),
    .rst       (rst),
    .bus       (bus_r),
    .busy      (busy_r),
    .dbg_state (st_r)
  );

  logic          stb0 = 1'b0, stb1 = 1'b0;
  req_t          drv0, drv1;
  logic          resp_ack = 1'b0, stray_ack = 1'b0, hold_ack = 1'b0;
  logic          fixed_en = 1'b0;
  logic [DW-1:0] fixed_dout = '0;
  logic [DW-1:0] resp_dout = '0;

  assign bus_r.m_stb   = {stb1, stb0};
  assign bus_r.m_we    = {drv1.we, drv0.we};
  assign bus_r.m0_addr = drv0.addr;
  assign bus_r.m1_addr = drv1.addr;
  assign bus_r.m0_din  = drv0.din;
  assign bus_r.m1_din  = drv1.din;
  assign bus_r.m0_dm   = drv0.dm;
  assign bus_r.m1_dm   = drv1.dm;
  assign bus_r.ws_ack  = resp_ack | stray_ack;
  assign bus_r.ws_dout = resp_dout;

  // ---------------- fixed-priority instance ----------------
  mem_line_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .DM_W(MW)) bus_p ();
  logic          busy_p;
  logic [1:0]    st_p;
  logic          p_stb0 = 1'b0, p_stb1 = 1'b0, p_ack = 1'b0;
  logic [DW-1:0] p_dout = '0;

  mem_line_arbiter #(.PRIO_MODE(PRIO_FIXED)) u_dut_pr (
    .clkCPU    (clkCPU),
    .rst       (rst),
    .bus       (bus_p),
    .busy      (busy_p),
    .dbg_state (st_p)
  );

  assign bus_p.m_stb   = {p_stb1, p_stb0};
  assign bus_p.m_we    = 2'b00;
  assign bus_p.m0_addr = 32'h0000_1000;
  assign bus_p.m1_addr = 32'h0000_2000;
  assign bus_p.m0_din  = '0;
  assign bus_p.m1_din  = '0;
  assign bus_p.m0_dm   = '0;
  assign bus_p.m1_dm   = '0;
  assign bus_p.ws_ack  = p_ack;
  assign bus_p.ws_dout = p_dout;

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_stb = 0;
  int pr_acks = 0;

  req_t       exp0_q[$];
  req_t       exp1_q[$];
  int         ack_q[$];
  logic [1:0] ack_log[$];
  logic [1:0] pr_q[$];

  function automatic void chk(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.addr = $urandom & 32'hFFFF_FFC0;
    r.we   = 1'($urandom_range(0, 1));
    r.din  = rand_line();
    r.dm   = {$urandom, $urandom};
    return r;
  endfunction

  // ---------------- reference model state (RR instance) ----------------
  bit         last_g = 1'b1;
  bit         model_idle = 1'b1;
  bit         in_txn = 1'b0;
  int         exp_stb_c = -1;
  int         stb_c = -1;
  int         rel_c = -1;
  int         idle_c = -1;
  logic [1:0] stb_prev = 2'b00;
  req_t       cur;
  bit         issue_now, wait_now;
  logic [1:0] exp_ack, exp_st;
  int         w;

  // Round-robin rule: a lone requester wins, a tie goes to the one not served last.
  function automatic int model_pick(input logic [1:0] s, input bit last);
    if (s == 2'b11) return last ? 0 : 1;
    return s[1] ? 1 : 0;
  endfunction

  // Wrapper model: ack 1..4 cycles into WAIT with fresh data.
  initial begin
    int lat;
    forever begin
      @(negedge clkCPU);
      if (!rst && bus_r.ws_stb && !hold_ack) begin
        lat = $urandom_range(1, 4);
        repeat (lat) @(posedge clkCPU);
        #1;
        resp_dout = fixed_en ? fixed_dout : rand_line();
        resp_ack  = 1'b1;
        @(posedge clkCPU);
        #1 resp_ack = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clkCPU);
      if (!rst && bus_p.ws_stb) begin
        repeat (2) @(posedge clkCPU);
        #1;
        p_dout = rand_line();
        p_ack  = 1'b1;
        @(posedge clkCPU);
        #1 p_ack = 1'b0;
      end
    end
  end

  // Monitor / scoreboard for the RR instance.
  always @(negedge clkCPU) begin
    if (rst) begin
      last_g     = 1'b1;
      model_idle = 1'b1;
      in_txn     = 1'b0;
      exp_stb_c  = -1;
      rel_c      = -1;
      idle_c     = -1;
      ack_q.delete();
    end else begin
      issue_now = (cyc == exp_stb_c);
      chk("ws_stb", 512'(bus_r.ws_stb), 512'(issue_now));
      if (bus_r.ws_stb) n_stb++;
      if (bus_r.ws_stb && issue_now) begin
        w = model_pick(stb_prev, last_g);
        if ((w == 0 && exp0_q.size() == 0) || (w == 1 && exp1_q.size() == 0)) begin
          chk("grant_has_request", 512'(0), 512'(1));
        end else begin
          cur = (w == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
          ack_q.push_back(w);
          in_txn = 1'b1;
          stb_c  = cyc;
        end
      end
      if (in_txn) begin
        chk("ws_addr", 512'(bus_r.ws_addr), 512'(cur.addr));
        chk("ws_we", 512'(bus_r.ws_we), 512'(cur.we));
        chk("ws_din", bus_r.ws_din, cur.din);
        chk("ws_dm", 512'(bus_r.ws_dm), 512'(cur.dm));
      end
      chk("ws_cyc", 512'(bus_r.ws_cyc), 512'(in_txn));
      chk("busy", 512'(busy_r), 512'(in_txn || cyc == rel_c));
      wait_now = in_txn && (cyc != stb_c);
      exp_st = in_txn ? ((cyc == stb_c) ? 2'd1 : 2'd2) : ((cyc == rel_c) ? 2'd3 : 2'd0);
      chk("dbg_state", 512'(st_r), 512'(exp_st));
      exp_ack = 2'b00;
      if (bus_r.ws_ack && wait_now && ack_q.size() > 0) begin
        w = ack_q.pop_front();
        exp_ack[w] = 1'b1;
        chk("m_dout", bus_r.m_dout, resp_dout);
        last_g = (w == 1);
        in_txn = 1'b0;
        rel_c  = cyc + 1;
        idle_c = cyc + 2;
      end
      chk("m_ack", 512'(bus_r.m_ack), 512'(exp_ack));
      if (bus_r.m_ack != 2'b00) ack_log.push_back(bus_r.m_ack);
      if (cyc == idle_c) model_idle = 1'b1;
      if (model_idle && bus_r.m_stb != 2'b00) begin
        model_idle = 1'b0;
        exp_stb_c  = cyc + 1;
      end
    end
    stb_prev = bus_r.m_stb;
    cyc++;
  end

  // Scoreboard for the fixed-priority instance.
  always @(negedge clkCPU) begin
    if (!rst) begin
      if (bus_p.ws_stb && pr_q.size() > 0) begin
        chk("prio_ws_addr", 512'(bus_p.ws_addr),
            512'((pr_q[0] == 2'b10) ? 32'h0000_2000 : 32'h0000_1000));
      end
      if (bus_p.m_ack != 2'b00) begin
        if (pr_q.size() == 0) chk("prio_unexpected_ack", 512'(bus_p.m_ack), 512'(0));
        else chk("prio_m_ack", 512'(bus_p.m_ack), 512'(pr_q.pop_front()));
        chk("prio_m_dout", bus_p.m_dout, p_dout);
        pr_acks++;
      end
    end
  end

  // Master driver: post expectation, raise request, hold until acked, optionally
  // keep m_stb up through one extra cycle.
  task automatic do_req(input int m, input req_t r, input bit hold);
    int t;
    if (m == 0) exp0_q.push_back(r);
    else        exp1_q.push_back(r);
    @(posedge clkCPU);
    #1;
    if (m == 0) begin drv0 = r; stb0 = 1'b1; end
    else        begin drv1 = r; stb1 = 1'b1; end
    t = 0;
    forever begin
      @(negedge clkCPU);
      if (bus_r.m_ack[m]) break;
      t++;
      if (t > 300) begin
        chk($sformatf("ack_timeout_m%0d", m), 512'(0), 512'(1));
        break;
      end
    end
    @(posedge clkCPU);
    #1;
    if (hold) begin
      @(posedge clkCPU);
      #1;
    end
    if (m == 0) stb0 = 1'b0;
    else        stb1 = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clkCPU);
    #1;
  endtask

  initial begin
    req_t r0, r1;
    int   t, s0;
    drv0 = '{addr: '0, we: 1'b0, din: '0, dm: '0};
    drv1 = '{addr: '0, we: 1'b0, din: '0, dm: '0};
    repeat (3) @(posedge clkCPU);
    #1 rst = 1'b0;
    @(negedge clkCPU);
    chk("reset_ws_addr", 512'(bus_r.ws_addr), 512'(0));
    chk("reset_ws_din", bus_r.ws_din, 512'(0));
    chk("reset_ws_dm", 512'(bus_r.ws_dm), 512'(0));
    chk("reset_ws_we", 512'(bus_r.ws_we), 512'(0));
    chk("reset_state", 512'(st_r), 512'(0));

    // Simultaneous requests out of reset: m0 first, then m1.
    ack_log.delete();
    r0 = rand_req();
    r1 = rand_req();
    fork
      do_req(0, r0, 1'b0);
      do_req(1, r1, 1'b0);
    join
    chk("tie_count", 512'(ack_log.size()), 512'(2));
    if (ack_log.size() == 2) begin
      chk("tie_first", 512'(ack_log[0]), 512'(2'b01));
      chk("tie_second", 512'(ack_log[1]), 512'(2'b10));
    end
    idle_cycles(3);

    // m0 line read with a fixed data pattern.
    fixed_en   = 1'b1;
    fixed_dout = {64{8'hA5}};
    r0 = '{addr: 32'h0000_0100, we: 1'b0, din: rand_line(), dm: '0};
    do_req(0, r0, 1'b0);
    fixed_en = 1'b0;
    idle_cycles(3);

    // m1 full-line write.
    r1 = '{addr: 32'h0000_0040, we: 1'b1, din: {16{32'h1234_5678}}, dm: {MW{1'b1}}};
    do_req(1, r1, 1'b0);
    idle_cycles(3);

    // m0 keeps m_stb up through RELEASE: exactly one strobe.
    s0 = n_stb;
    do_req(0, rand_req(), 1'b1);
    idle_cycles(6);
    chk("release_single_stb", 512'(n_stb - s0), 512'(1));

    // Reset during WAIT abandons the transaction; a stray ack is ignored.
    hold_ack = 1'b1;
    r0 = rand_req();
    exp0_q.push_back(r0);
    drv0 = r0;
    stb0 = 1'b1;
    t = 0;
    do begin
      @(negedge clkCPU);
      t++;
    end while (!bus_r.ws_stb && t < 50);
    chk("rst_test_issue", 512'(bus_r.ws_stb), 512'(1));
    idle_cycles(2);
    rst  = 1'b1;
    stb0 = 1'b0;
    @(posedge clkCPU);
    #1 rst = 1'b0;
    @(negedge clkCPU);
    chk("rst_mid_state", 512'(st_r), 512'(0));
    chk("rst_mid_ws_cyc", 512'(bus_r.ws_cyc), 512'(0));
    chk("rst_mid_m_ack", 512'(bus_r.m_ack), 512'(0));
    @(posedge clkCPU);
    #1 stray_ack = 1'b1;
    @(negedge clkCPU);
    chk("stray_ack", 512'(bus_r.m_ack), 512'(0));
    @(posedge clkCPU);
    #1 stray_ack = 1'b0;
    hold_ack = 1'b0;
    idle_cycles(3);

    // Both masters re-requesting back to back: RR alternates.
    ack_log.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) do_req(0, rand_req(), 1'b0);
      end
      begin
        for (int i = 0; i < 3; i++) do_req(1, rand_req(), 1'b0);
      end
    join
    chk("rr_count", 512'(ack_log.size()), 512'(6));
    for (int i = 1; i < ack_log.size(); i++) begin
      chk($sformatf("rr_alternate_%0d", i), 512'(ack_log[i] != ack_log[i-1]), 512'(1));
    end
    idle_cycles(3);

    // Random traffic from both masters.
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          idle_cycles($urandom_range(0, 3));
          do_req(0, rand_req(), ($urandom_range(0, 3) == 0));
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          idle_cycles($urandom_range(0, 3));
          do_req(1, rand_req(), ($urandom_range(0, 3) == 0));
        end
      end
    join
    idle_cycles(5);

    // Fixed priority: m1 keeps requesting, m0 waits until m1 stops.
    for (int i = 0; i < 4; i++) pr_q.push_back(2'b10);
    pr_q.push_back(2'b01);
    @(posedge clkCPU);
    #1;
    p_stb0 = 1'b1;
    p_stb1 = 1'b1;
    t = 0;
    while (pr_acks < 4 && t < 200) begin
      @(negedge clkCPU);
      #1 t++;
    end
    chk("prio_m1_acks", 512'(pr_acks), 512'(4));
    @(posedge clkCPU);
    #1 p_stb1 = 1'b0;
    t = 0;
    while (pr_acks < 5 && t < 200) begin
      @(negedge clkCPU);
      #1 t++;
    end
    chk("prio_total_acks", 512'(pr_acks), 512'(5));
    @(posedge clkCPU);
    #1 p_stb0 = 1'b0;
    idle_cycles(6);

    chk("pending_m0", 512'(exp0_q.size()), 512'(0));
    chk("pending_m1", 512'(exp1_q.size()), 512'(0));
    chk("pending_acks", 512'(ack_q.size()), 512'(0));
    chk("prio_pending", 512'(pr_q.size()), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1, "timeout");
  end

endmodule
